fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
Read-side controller for the team's synchronous FIFO. It drains the FIFO through its rd_en/empty interface, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents the words as a valid/ready stream. It never issues a read to an empty FIFO, supports a flush that discards all queued data, and keeps a sticky error if the FIFO ever reports underflow.

Parameters:
FIFO_WIDTH, 16, data word width; must match the FIFO.
CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
fifo_dout  in  FIFO_WIDTH  FIFO read data; valid the cycle after an accepted read.
fifo_empty  in  1  FIFO empty flag.
fifo_underflow  in  1  FIFO underflow flag.
fifo_rd_en  out  1  read request to the FIFO.
out_data  out  FIFO_WIDTH  stream data; equals the skid-buffer head.
out_valid  out  1  stream valid.
out_ready  in  1  stream ready from the downstream consumer.
flush  in  1  request to discard buffered data and drain the FIFO.
flush_done  out  1  one-cycle pulse when a flush completes.
underflow_err  out  1  sticky; set if fifo_underflow is ever seen high.
words_out  out  CNT_WIDTH  count of words delivered on the stream; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Takes priority over everything, including mid-flush and mid-read.
  - Clears state to IDLE, occ=0, inflight=0, words_out=0, underflow_err=0.
  - Forces flush_done=0, out_valid=0, out_data=0, fifo_rd_en=0.
- Internal state:
  - occ (0..2): skid-buffer occupancy.
  - inflight (0..1): registered copy of last cycle's fifo_rd_en.
  - pop = out_valid && out_ready.
- fifo_rd_en is combinational and needs !rst && !fifo_empty.
  - STREAM: also needs (occ + inflight - pop) < 2.
  - FLUSH: no credit condition.
  - IDLE: never asserted.
- Latency:
  - fifo_rd_en high in cycle N.
  - fifo_dout is sampled at the end of cycle N+1.
  - The word appears with out_valid=1 in cycle N+2.
- Throughput:
  - Sustains 1 word/cycle when out_ready stays high and the FIFO stays non-empty.
  - Buffer never overflows: the credit rule guarantees occ<=2.
- Buffer behaviour:
  - Order is strict FIFO.
  - A push and a pop in the same cycle leave occ unchanged.
  - out_data and out_valid must not change while out_valid && !out_ready (stable hold).
- FSM states IDLE, STREAM, FLUSH:
  - IDLE: leaves the reset state to STREAM on the next cycle.
  - STREAM:
    - Normal operation.
    - flush=1 -> FLUSH next cycle.
    - The word delivered in the same cycle as flush=1 still counts if popped.
  - FLUSH, on entry:
    - occ is cleared and out_valid=0.
    - Any in-flight word is discarded on return.
  - FLUSH, while active:
    - fifo_rd_en=!fifo_empty every cycle.
    - Returned data is discarded.
    - flush input is ignored.
  - FLUSH, exit:
    - Condition: fifo_empty && inflight==0.
    - flush_done pulses for 1 cycle; next state is STREAM.
- words_out increments on every pop; it wraps from 2^CNT_WIDTH-1 to 0.
- underflow_err:
  - Set on any cycle with fifo_underflow=1.
  - Cleared only by rst.
  - A correct design never causes it; it flags FIFO or integration faults.

Test Plan:
- Reset: rst=1 for 2 cycles with FIFO non-empty -> fifo_rd_en=0, out_valid=0, words_out=0, flush_done=0, underflow_err=0.
- Single word: FIFO holds 16'hA5A5, out_ready=1 -> fifo_rd_en for 1 cycle (cycle N); out_valid=1 with out_data=16'hA5A5 in cycle N+2; words_out=1; no further fifo_rd_en once fifo_empty=1.
- Back-to-back: FIFO preloaded with 8 words 0..7, out_ready=1 -> 8 consecutive out_valid cycles carrying 0..7 in order; words_out=8; fifo_underflow never high.
- Backpressure: out_ready=0 with 8 words queued -> at most 2 fifo_rd_en pulses; occ=2; out_data=0 held stable. Raise out_ready -> words 0..7 delivered in order, none lost or duplicated.
- Flush: 5 words queued, 2 already buffered, pulse flush -> out_valid=0 from the next cycle; FIFO drained to empty; flush_done pulses exactly once; words_out unchanged. A later write of 16'h1234 streams out normally.
- Error and wrap:
  - Force fifo_underflow=1 for 1 cycle -> underflow_err=1 and stays high until rst.
  - With CNT_WIDTH=4, deliver 17 words -> words_out=1.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: drains it through rd_en/empty,
// absorbs the one-cycle read latency in a 2-entry skid buffer and streams words out.
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  underflow_err,
  output logic [CNT_WIDTH-1:0]  words_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [FIFO_WIDTH-1:0] buf0_q, buf0_d;
  logic [FIFO_WIDTH-1:0] buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]  words_q, words_d;
  logic                  underflow_err_q;
  logic                  flush_done_q, flush_done_d;
  logic                  rd_en_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  flush_exit_s;
  logic [2:0]            pending_s;

  assign out_valid     = (occ_q != 2'd0);
  assign out_data      = buf0_q;
  assign flush_done    = flush_done_q;
  assign underflow_err = underflow_err_q;
  assign words_out     = words_q;
  assign fifo_rd_en    = rd_en_s;

  assign pop_s        = out_valid && out_ready;
  // Words already owned by the buffer once this cycle's pop leaves; must stay below 2.
  assign pending_s    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign flush_exit_s = fifo_empty && !inflight_q;

  // Next-state, read request, skid-buffer update and delivered-word count.
  always_comb begin
    state_d      = state_q;
    occ_d        = occ_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    flush_done_d = 1'b0;
    rd_en_s      = 1'b0;
    push_s       = 1'b0;

    if (pop_s) begin
      words_d = words_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      words_d = words_q;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        rd_en_s = !rst && !fifo_empty && (pending_s < 3'd2);
        push_s  = inflight_q;
        if (flush) begin
          // Buffered and in-flight words are dropped; the returning word is ignored in FLUSH.
          state_d = ST_FLUSH;
          occ_d   = 2'd0;
        end else begin
          case ({push_s, pop_s})
            2'b10: begin
              occ_d = occ_q + 2'd1;
              if (occ_q == 2'd0) begin
                buf0_d = fifo_dout;
              end else begin
                buf1_d = fifo_dout;
              end
            end
            2'b01: begin
              occ_d  = occ_q - 2'd1;
              buf0_d = buf1_q;
            end
            2'b11: begin
              if (occ_q == 2'd2) begin
                buf0_d = buf1_q;
                buf1_d = fifo_dout;
              end else begin
                buf0_d = fifo_dout;
              end
            end
            default: begin
              occ_d = occ_q;
            end
          endcase
        end
      end
      ST_FLUSH: begin
        rd_en_s = !rst && !fifo_empty;
        if (flush_exit_s) begin
          state_d      = ST_STREAM;
          flush_done_d = 1'b1;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        occ_d   = 2'd0;
      end
    endcase
  end

  // State, buffer, counters and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      occ_q           <= 2'd0;
      inflight_q      <= 1'b0;
      buf0_q          <= {FIFO_WIDTH{1'b0}};
      buf1_q          <= {FIFO_WIDTH{1'b0}};
      words_q         <= {CNT_WIDTH{1'b0}};
      underflow_err_q <= 1'b0;
      flush_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      occ_q           <= occ_d;
      inflight_q      <= rd_en_s;
      buf0_q          <= buf0_d;
      buf1_q          <= buf1_d;
      words_q         <= words_d;
      underflow_err_q <= underflow_err_q | fifo_underflow;
      flush_done_q    <= flush_done_d;
    end
  end

endmodule
